// File: rtl/pulse_gen.sv
// Multi-channel programmable pulse generator with shadow/active config per channel.
// Optional single-period mode is compiled in with `define PULSE_GEN_ONESHOT_EN.
module pulse_gen #(
    parameter int unsigned NUM_CH = 4,   // 1..32
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic [NUM_CH-1:0] load,
    input  logic [CNT_W-1:0]  cfg_period,
    input  logic [CNT_W-1:0]  cfg_width,
    input  logic [CNT_W-1:0]  cfg_phase,
    output logic [NUM_CH-1:0] pulse,
    output logic [NUM_CH-1:0] wrap,
    output logic [NUM_CH-1:0] cfg_pend
`ifdef PULSE_GEN_ONESHOT_EN
    ,
    input  logic [NUM_CH-1:0] oneshot,
    output logic [NUM_CH-1:0] done
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_e;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        state_e           state_q, state_d;
        logic [CNT_W-1:0] count_q, count_d;
        logic [CNT_W-1:0] shd_per_q, shd_per_d;
        logic [CNT_W-1:0] shd_wid_q, shd_wid_d;
        logic [CNT_W-1:0] shd_ph_q,  shd_ph_d;
        logic [CNT_W-1:0] act_per_q, act_per_d;
        logic [CNT_W-1:0] act_wid_q, act_wid_d;
        logic [CNT_W-1:0] act_ph_q,  act_ph_d;
        logic             pulse_q, pulse_d;
        logic             wrap_q,  wrap_d;
        logic             pend_q,  pend_d;
        logic             os_q,    os_d;
        logic             os_in;
        logic [CNT_W-1:0] p_eff, p_last, ph_eff, cnt_inc;
        logic             at_end, at_wrap, xfer;
`ifdef PULSE_GEN_ONESHOT_EN
        logic             done_q, done_d;
        assign os_in = oneshot[g];
`else
        assign os_in = 1'b0;
`endif

        // Effective period/phase derived from the active config only.
        assign p_eff   = (act_per_q == '0) ? CNT_W'(1) : act_per_q;
        assign p_last  = p_eff - CNT_W'(1);
        assign ph_eff  = (act_ph_q < p_eff) ? act_ph_q : '0;
        assign cnt_inc = count_q + CNT_W'(1);
        assign at_end  = (state_q == ST_RUN) && (count_q == p_last);
        assign at_wrap = en && ch_en[g] && at_end;
        assign xfer    = pend_q && (!ch_en[g] || at_wrap);

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                state_q   <= ST_IDLE;
                count_q   <= '0;
                shd_per_q <= CNT_W'(1);
                shd_wid_q <= '0;
                shd_ph_q  <= '0;
                act_per_q <= CNT_W'(1);
                act_wid_q <= '0;
                act_ph_q  <= '0;
                pulse_q   <= 1'b0;
                wrap_q    <= 1'b0;
                pend_q    <= 1'b0;
                os_q      <= 1'b0;
            end else begin
                state_q   <= state_d;
                count_q   <= count_d;
                shd_per_q <= shd_per_d;
                shd_wid_q <= shd_wid_d;
                shd_ph_q  <= shd_ph_d;
                act_per_q <= act_per_d;
                act_wid_q <= act_wid_d;
                act_ph_q  <= act_ph_d;
                pulse_q   <= pulse_d;
                wrap_q    <= wrap_d;
                pend_q    <= pend_d;
                os_q      <= os_d;
            end
        end

        always_comb begin
            state_d = state_q;
            if (en) begin
                if (!ch_en[g]) begin
                    state_d = ST_IDLE;
                end else begin
                    unique case (state_q)
                        ST_IDLE: state_d = ST_RUN;
                        ST_RUN:  if (at_end && os_q) state_d = ST_HALT;
                        ST_HALT: state_d = ST_HALT;
                        default: state_d = ST_IDLE;
                    endcase
                end
            end
        end

        // A load in the transfer cycle still moves the old shadow to active.
        always_comb begin
            shd_per_d = load[g] ? cfg_period : shd_per_q;
            shd_wid_d = load[g] ? cfg_width  : shd_wid_q;
            shd_ph_d  = load[g] ? cfg_phase  : shd_ph_q;
            act_per_d = xfer ? shd_per_q : act_per_q;
            act_wid_d = xfer ? shd_wid_q : act_wid_q;
            act_ph_d  = xfer ? shd_ph_q  : act_ph_q;
            pend_d    = load[g] || (pend_q && !xfer);
        end

        always_comb begin
            count_d = count_q;
            pulse_d = pulse_q;
            wrap_d  = 1'b0;
            os_d    = os_q;
`ifdef PULSE_GEN_ONESHOT_EN
            done_d  = 1'b0;
`endif
            if (en) begin
                if (!ch_en[g]) begin
                    count_d = '0;
                    pulse_d = 1'b0;
                end else begin
                    unique case (state_q)
                        ST_IDLE: begin
                            count_d = ph_eff;
                            pulse_d = (ph_eff < act_wid_q);
                            os_d    = os_in;
                        end
                        ST_RUN: begin
                            if (at_end) begin
                                count_d = '0;
                                wrap_d  = 1'b1;
                                // New period starts with whatever config applies from here on.
                                pulse_d = !os_q && (act_wid_d != '0);
`ifdef PULSE_GEN_ONESHOT_EN
                                done_d  = os_q;
`endif
                            end else begin
                                count_d = cnt_inc;
                                pulse_d = (cnt_inc < act_wid_q);
                            end
                        end
                        ST_HALT: begin
                            count_d = '0;
                            pulse_d = 1'b0;
                        end
                        default: begin
                            count_d = '0;
                            pulse_d = 1'b0;
                        end
                    endcase
                end
            end
        end

`ifdef PULSE_GEN_ONESHOT_EN
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) done_q <= 1'b0;
            else      done_q <= done_d;
        end
        assign done[g] = done_q;
`endif

        assign pulse[g]    = pulse_q;
        assign wrap[g]     = wrap_q;
        assign cfg_pend[g] = pend_q;
    end

endmodule

// File: tb/tb_pulse_gen.sv
// Directed self-checking bench for pulse_gen (4 channels, 16-bit counters).
module tb_pulse_gen;
    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [3:0]  ch_en;
    logic [3:0]  load;
    logic [15:0] cfg_period, cfg_width, cfg_phase;
    logic [3:0]  pulse, wrap, cfg_pend;
`ifdef PULSE_GEN_ONESHOT_EN
    logic [3:0]  oneshot;
    logic [3:0]  done;
`endif
    int n_vec = 0;
    int n_bad = 0;

    pulse_gen #(.NUM_CH(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .en(en), .ch_en(ch_en), .load(load),
        .cfg_period(cfg_period), .cfg_width(cfg_width), .cfg_phase(cfg_phase),
        .pulse(pulse), .wrap(wrap), .cfg_pend(cfg_pend)
`ifdef PULSE_GEN_ONESHOT_EN
        , .oneshot(oneshot), .done(done)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load_cfg(input int ch, input logic [15:0] per, input logic [15:0] wid,
                            input logic [15:0] ph);
        ch_en[ch] = 1'b0;
        load[ch]  = 1'b1;
        cfg_period = per; cfg_width = wid; cfg_phase = ph;
        tick;
        load = '0;
        n_vec++;
        if (cfg_pend[ch] !== 1'b1) begin n_bad++; $display("FAIL load_pend ch%0d: got %b want 1", ch, cfg_pend[ch]); end
        tick;
        n_vec++;
        if (cfg_pend[ch] !== 1'b0) begin n_bad++; $display("FAIL load_xfer ch%0d: got %b want 0", ch, cfg_pend[ch]); end
    endtask

    task automatic test_reset;
        #3;
        n_vec++; if (pulse !== 4'h0)    begin n_bad++; $display("FAIL rst_pulse: got %h want 0", pulse); end
        n_vec++; if (wrap !== 4'h0)     begin n_bad++; $display("FAIL rst_wrap: got %h want 0", wrap); end
        n_vec++; if (cfg_pend !== 4'h0) begin n_bad++; $display("FAIL rst_pend: got %h want 0", cfg_pend); end
        @(negedge clk);
        rst = 1'b1;
        tick;
        n_vec++; if (pulse !== 4'h0) begin n_bad++; $display("FAIL idle_pulse: got %h want 0", pulse); end
    endtask

    task automatic test_basic;
        load_cfg(0, 16'd10, 16'd3, 16'd0);
        ch_en[0] = 1'b1;
        for (int k = 0; k < 30; k++) begin
            tick;
            n_vec++;
            if (pulse[0] !== ((k % 10) < 3)) begin n_bad++; $display("FAIL basic_pulse k=%0d: got %b want %b", k, pulse[0], ((k % 10) < 3)); end
            n_vec++;
            if (wrap[0] !== (k > 0 && k % 10 == 0)) begin n_bad++; $display("FAIL basic_wrap k=%0d: got %b want %b", k, wrap[0], (k > 0 && k % 10 == 0)); end
        end
        ch_en[0] = 1'b0;
        tick;
        n_vec++; if (pulse[0] !== 1'b0) begin n_bad++; $display("FAIL basic_off: got %b want 0", pulse[0]); end
    endtask

    task automatic test_phase;
        int c;
        load_cfg(1, 16'd8, 16'd2, 16'd6);
        ch_en[1] = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick;
            c = (6 + k) % 8;
            n_vec++;
            if (pulse[1] !== (c < 2)) begin n_bad++; $display("FAIL phase_pulse k=%0d: got %b want %b", k, pulse[1], (c < 2)); end
            n_vec++;
            if (wrap[1] !== (k > 0 && c == 0)) begin n_bad++; $display("FAIL phase_wrap k=%0d: got %b want %b", k, wrap[1], (k > 0 && c == 0)); end
        end
        ch_en[1] = 1'b0;
        tick;
    endtask

    task automatic test_reconfig;
        load_cfg(0, 16'd10, 16'd3, 16'd0);
        ch_en[0] = 1'b1;
        for (int j = 0; j < 4; j++) begin
            tick;
            n_vec++; if (pulse[0] !== (j < 3)) begin n_bad++; $display("FAIL recfg_pre j=%0d: got %b want %b", j, pulse[0], (j < 3)); end
        end
        load[0] = 1'b1; cfg_period = 16'd4; cfg_width = 16'd1; cfg_phase = 16'd0;
        tick;
        load = '0;
        for (int j = 4; j < 10; j++) begin
            if (j > 4) tick;
            n_vec++; if (cfg_pend[0] !== 1'b1) begin n_bad++; $display("FAIL recfg_pend j=%0d: got %b want 1", j, cfg_pend[0]); end
            n_vec++; if (pulse[0] !== 1'b0)    begin n_bad++; $display("FAIL recfg_low j=%0d: got %b want 0", j, pulse[0]); end
        end
        for (int k = 0; k < 12; k++) begin
            tick;
            n_vec++; if (pulse[0] !== (k % 4 == 0)) begin n_bad++; $display("FAIL recfg_pulse k=%0d: got %b want %b", k, pulse[0], (k % 4 == 0)); end
            n_vec++; if (wrap[0] !== (k % 4 == 0))  begin n_bad++; $display("FAIL recfg_wrap k=%0d: got %b want %b", k, wrap[0], (k % 4 == 0)); end
            n_vec++; if (cfg_pend[0] !== 1'b0)      begin n_bad++; $display("FAIL recfg_clr k=%0d: got %b want 0", k, cfg_pend[0]); end
        end
        ch_en[0] = 1'b0;
        tick;
    endtask

    task automatic test_edges;
        load_cfg(2, 16'd10, 16'd0, 16'd0);
        ch_en[2] = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick;
            n_vec++; if (pulse[2] !== 1'b0) begin n_bad++; $display("FAIL w0_pulse k=%0d: got %b want 0", k, pulse[2]); end
        end
        load_cfg(2, 16'd10, 16'd12, 16'd0);
        ch_en[2] = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick;
            n_vec++; if (pulse[2] !== 1'b1) begin n_bad++; $display("FAIL wbig_pulse k=%0d: got %b want 1", k, pulse[2]); end
        end
        load_cfg(2, 16'd0, 16'd0, 16'd0);
        ch_en[2] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick;
            n_vec++; if (wrap[2] !== (k > 0)) begin n_bad++; $display("FAIL p0_wrap k=%0d: got %b want %b", k, wrap[2], (k > 0)); end
            n_vec++; if (pulse[2] !== 1'b0)   begin n_bad++; $display("FAIL p0_pulse k=%0d: got %b want 0", k, pulse[2]); end
        end
        load_cfg(2, 16'd5, 16'd1, 16'd7);
        ch_en[2] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick;
            n_vec++; if (pulse[2] !== (k % 5 == 0)) begin n_bad++; $display("FAIL bigph_pulse k=%0d: got %b want %b", k, pulse[2], (k % 5 == 0)); end
        end
        ch_en[2] = 1'b0;
        tick;
    endtask

    task automatic test_freeze;
        load_cfg(0, 16'd10, 16'd6, 16'd0);
        ch_en[0] = 1'b1;
        for (int k = 0; k < 6; k++) tick;
        n_vec++; if (pulse[0] !== 1'b1) begin n_bad++; $display("FAIL frz_pre: got %b want 1", pulse[0]); end
        en = 1'b0;
        load[3] = 1'b1; cfg_period = 16'd3; cfg_width = 16'd1; cfg_phase = 16'd0;
        for (int k = 0; k < 5; k++) begin
            tick;
            load = '0;
            n_vec++; if (pulse[0] !== 1'b1) begin n_bad++; $display("FAIL frz_pulse k=%0d: got %b want 1", k, pulse[0]); end
            n_vec++; if (wrap[0] !== 1'b0)  begin n_bad++; $display("FAIL frz_wrap k=%0d: got %b want 0", k, wrap[0]); end
            if (k < 2) begin
                n_vec++; if (cfg_pend[3] !== (k == 0)) begin n_bad++; $display("FAIL frz_load k=%0d: got %b want %b", k, cfg_pend[3], (k == 0)); end
            end
        end
        en = 1'b1;
        for (int c = 6; c < 12; c++) begin
            tick;
            n_vec++; if (pulse[0] !== ((c % 10) < 6)) begin n_bad++; $display("FAIL frz_resume c=%0d: got %b want %b", c, pulse[0], ((c % 10) < 6)); end
            n_vec++; if (wrap[0] !== (c == 10))       begin n_bad++; $display("FAIL frz_rwrap c=%0d: got %b want %b", c, wrap[0], (c == 10)); end
        end
        ch_en[0] = 1'b0;
        tick;
    endtask

    task automatic test_back_to_back;
        int c1;
        load_cfg(0, 16'd3, 16'd1, 16'd0);
        load_cfg(1, 16'd5, 16'd2, 16'd1);
        ch_en[1:0] = 2'b11;
        for (int k = 0; k < 15; k++) begin
            tick;
            c1 = (1 + k) % 5;
            n_vec++; if (pulse[0] !== (k % 3 == 0)) begin n_bad++; $display("FAIL b2b_p0 k=%0d: got %b want %b", k, pulse[0], (k % 3 == 0)); end
            n_vec++; if (pulse[1] !== (c1 < 2))     begin n_bad++; $display("FAIL b2b_p1 k=%0d: got %b want %b", k, pulse[1], (c1 < 2)); end
        end
        ch_en = '0;
        tick;
    endtask

`ifdef PULSE_GEN_ONESHOT_EN
    task automatic test_oneshot;
        load_cfg(2, 16'd5, 16'd2, 16'd0);
        oneshot[2] = 1'b1;
        ch_en[2] = 1'b1;
        for (int k = 0; k < 9; k++) begin
            tick;
            n_vec++; if (pulse[2] !== (k < 2))  begin n_bad++; $display("FAIL os_pulse k=%0d: got %b want %b", k, pulse[2], (k < 2)); end
            n_vec++; if (done[2] !== (k == 5))  begin n_bad++; $display("FAIL os_done k=%0d: got %b want %b", k, done[2], (k == 5)); end
            n_vec++; if (wrap[2] !== (k == 5))  begin n_bad++; $display("FAIL os_wrap k=%0d: got %b want %b", k, wrap[2], (k == 5)); end
        end
        ch_en[2] = 1'b0;
        tick;
        ch_en[2] = 1'b1;
        tick;
        n_vec++; if (pulse[2] !== 1'b1) begin n_bad++; $display("FAIL os_restart: got %b want 1", pulse[2]); end
        ch_en[2] = 1'b0; oneshot = '0;
        tick;
    endtask
`endif

    task automatic test_async_reset;
        load_cfg(0, 16'd10, 16'd3, 16'd0);
        ch_en[0] = 1'b1;
        tick;
        n_vec++; if (pulse[0] !== 1'b1) begin n_bad++; $display("FAIL ar_pre: got %b want 1", pulse[0]); end
        #2 rst = 1'b0;
        #1;
        n_vec++; if (pulse[0] !== 1'b0) begin n_bad++; $display("FAIL ar_async: got %b want 0", pulse[0]); end
        tick;
        #2 rst = 1'b1;
        #1;
        n_vec++; if (pulse[0] !== 1'b0)    begin n_bad++; $display("FAIL ar_hold: got %b want 0", pulse[0]); end
        n_vec++; if (cfg_pend !== 4'h0)    begin n_bad++; $display("FAIL ar_pend: got %h want 0", cfg_pend); end
        tick;
        n_vec++; if (pulse[0] !== 1'b0) begin n_bad++; $display("FAIL ar_defcfg: got %b want 0", pulse[0]); end
        ch_en = '0;
        tick;
    endtask

    initial begin
        rst = 1'b0; en = 1'b1; ch_en = '0; load = '0;
        cfg_period = '0; cfg_width = '0; cfg_phase = '0;
`ifdef PULSE_GEN_ONESHOT_EN
        oneshot = '0;
`endif
        test_reset;
        test_basic;
        test_phase;
        test_reconfig;
        test_edges;
        test_freeze;
        test_back_to_back;
`ifdef PULSE_GEN_ONESHOT_EN
        test_oneshot;
`endif
        test_async_reset;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/pulse_gen.md
Name: pulse_gen

Overview:
- Multi-channel, runtime-programmable pulse generator. Successor to the fixed-parameter single-channel pulse block.
- Each channel has its own period, high width and phase offset, loaded through a shadow/active register pair. Config changes take effect only at a period boundary, so updates are glitch-free.
- Sits beside the system timing logic and drives strobes to samplers, LEDs and sync outputs.

Parameters:
- NUM_CH, 4, number of independent pulse channels (1..32)
- CNT_W, 16, width of the period, width and phase fields and of each channel counter

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  asynchronous, active-low reset (0 = reset)
- en  input  1  global enable; 0 freezes all counters and outputs
- ch_en  input  NUM_CH  per-channel run enable
- load  input  NUM_CH  per-channel config capture strobe
- cfg_period  input  CNT_W  period in cycles, shared config bus
- cfg_width  input  CNT_W  high time in cycles, shared config bus
- cfg_phase  input  CNT_W  counter start value, shared config bus
- pulse  output  NUM_CH  registered pulse outputs
- wrap  output  NUM_CH  one-cycle strobe, channel counter wrapped this cycle
- cfg_pend  output  NUM_CH  shadow config waiting to be applied

Behaviour:
- Reset (rst=0, async):
  - All outputs cleared: pulse=0, wrap=0, cfg_pend=0.
  - Counts cleared to 0.
  - Shadow and active config set to period=1, width=0, phase=0.
- load[i]=1 captures the cfg_* buses into the shadow regs of channel i and sets cfg_pend[i]. Load is accepted even when en=0.
- Shadow to active transfer for channel i, when cfg_pend[i]=1:
  - Occurs at its wrap cycle (count == P-1 with en=1), or on any cycle where ch_en[i]=0.
  - cfg_pend[i] clears in the same cycle.
  - A load coinciding with the transfer cycle wins: the new values go to shadow, cfg_pend stays 1, and the old shadow still moves to active.
- Effective period P = max(active_period, 1).
- Effective phase = active_phase if active_phase < P, else 0.
- Channel states, evaluated only when en=1:
  - IDLE (ch_en[i]=0): count<=0, pulse<=0, wrap<=0.
  - START (first cycle with ch_en[i]=1): count<=phase, pulse<=(phase<width), wrap<=0.
  - RUN: if count==P-1 then count<=0, wrap<=1, pulse<=(0<width). Otherwise count<=count+1, wrap<=0, pulse<=(count+1<width).
- pulse reflects the count value held in the same cycle (registered compare on the next count).
- Width rules:
  - width=0: pulse stays 0.
  - width>=P: pulse stays 1.
  - P=1: count stays 0 and wrap is asserted every cycle.
- Counter arithmetic is unsigned CNT_W with no overflow: count never exceeds P-1.
- en=0: count, pulse and the START/RUN state hold; wrap<=0. The shadow/active transfer is suppressed unless ch_en[i]=0.
- ch_en deasserted mid-period: the next cycle is IDLE (pulse=0). Re-enabling restarts at phase.
- Reset mid-operation aborts immediately. Outputs stay at their reset values until the first clk edge after rst=1.
- Channels are fully independent. Latency from ch_en rise to first pulse update is 1 cycle.

Optional Feature:
- Macro PULSE_GEN_ONESHOT_EN.
- When defined:
  - Adds input oneshot (NUM_CH) and output done (NUM_CH).
  - A channel with oneshot[i]=1 at START runs exactly one period.
  - At its wrap it enters a HALT state: count<=0, pulse<=0, done[i]<=1 as a one-cycle strobe, and wrap[i] still strobes.
  - It stays halted until ch_en[i] is deasserted and reasserted.
- When not defined: no extra ports, and all channels are free-running.

Test Plan:
- Reset, then ch0 load period=10 width=3 phase=0, ch_en[0]=1 -> pulse[0] pattern 1,1,1 then 0 x7, repeating; wrap[0] every 10th cycle on count=9.
- ch1 period=8 width=2 phase=6 -> first cycles pulse 0,0 (count 6,7) then 1,1 at counts 0,1; wrap on the 2nd cycle after start.
- ch0 running at period=10; load period=4 width=1 at count=3 -> cfg_pend=1 until count 9 wrap, then 4-cycle pattern 1,0,0,0; no truncated or extended pulse.
- Edge configs: width=0 -> pulse always 0; width=12 with period=10 -> always 1; period=0 -> P=1, wrap every cycle.
- en=0 for 5 cycles mid-period at count=5 -> pulse and count hold, wrap=0; resumes at count=6. rst=0 asserted mid-pulse -> pulse=0 immediately (async).
- With PULSE_GEN_ONESHOT_EN, oneshot[2]=1, period=5 width=2 -> pulse 1,1,0,0,0; done[2] and wrap[2] on cycle 5; pulse stays 0 after that until ch_en[2] toggles.
